mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 33 +++
 rtl/mdu_ctrl_div_core.sv | 32 +++
 rtl/mdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
// Shared definitions for the multiply/divide unit controller:
//   - operation encodings presented on the op port
//   - FSM state encodings
//   - divide iteration count
//   - operand magnitude helper used when loading the divider
package mdu_ctrl_pkg;

    // Operation encodings (op port)
    localparam logic [1:0] MDU_DIV   = 2'b00;
    localparam logic [1:0] MDU_DIVU  = 2'b01;
    localparam logic [1:0] MDU_MULT  = 2'b10;
    localparam logic [1:0] MDU_MULTU = 2'b11;

    // One restoring step per cycle, one cycle per quotient bit
    localparam int MDU_DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } state_e;

    // Absolute value for signed operands. The two's complement of
    // 32'h80000000 is itself, which read as unsigned is the correct
    // magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// div_core
// One restoring division step, purely combinational.
// Ports:
//   rem_in   [31:0]  partial remainder
//   quo_in   [31:0]  quotient shift register (dividend bits shift out of
//                    the top, quotient bits shift in at the bottom)
//   divisor  [31:0]  divisor magnitude (non-zero)
//   rem_out  [31:0]  next partial remainder
//   quo_out  [31:0]  next quotient shift register
module div_core (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic        fits;

    always_comb begin
        // Bring the next dividend bit into the remainder; 33 bits because the
        // remainder can be up to divisor-1 before the shift.
        shifted = {rem_in, quo_in[31]};
        fits    = (shifted >= {1'b0, divisor});
        // When the subtraction fits, the difference is below the divisor, so
        // a 32-bit modular subtract gives the exact value.
        rem_out = fits ? (shifted[31:0] - divisor) : shifted[31:0];
        quo_out = {quo_in[30:0], fits};
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Multi-cycle multiply/divide unit controller for the EX stage.
// Multiplies take one cycle in MUL; divides run 32 restoring steps in DIV
// followed by a sign fix-up in SIGN; every operation ends in a one-cycle
// DONE that pulses result_valid and releases the pipeline stall.
// Ports:
//   clk          clock, all state on rising edge
//   resetn       synchronous active-low reset
//   start        EX request, held while EX is stalled
//   op [1:0]     00 DIV, 01 DIVU, 10 MULT, 11 MULTU
//   src_a [31:0] dividend / multiplicand
//   src_b [31:0] divisor / multiplier
//   flush        abandon any operation, return to IDLE
//   stall_req    stall request from EX back
//   result[63:0] {hi, lo}; divides give {remainder, quotient}
//   result_valid one-cycle pulse qualifying result
//   div0         divisor was zero, qualified by result_valid
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic [63:0] result,
    output logic        result_valid,
    output logic        div0
);

    localparam logic [4:0] DIV_LAST = 5'(MDU_DIV_CYCLES - 1);

    state_e      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic        signed_reg;
    logic        neg_q_reg, neg_r_reg;
    logic        div0_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] rem_reg, quo_reg, dvs_reg;
    logic [63:0] result_reg;

    logic        accept;
    logic        op_is_mul, op_is_signed, op_div0;
    logic [31:0] rem_step, quo_step;
    logic [63:0] ext_a, ext_b, product;

    assign op_is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    assign op_is_signed = (op == MDU_DIV)  || (op == MDU_MULT);
    assign op_div0      = !op_is_mul && (src_b == 32'd0);
    assign accept       = (state_reg == IDLE) && start && !flush;

    div_core u_div_core (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (dvs_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned multiplies.
    assign ext_a   = {{32{signed_reg & a_reg[31]}}, a_reg};
    assign ext_b   = {{32{signed_reg & b_reg[31]}}, b_reg};
    assign product = ext_a * ext_b;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (op_is_mul)
                        state_next = MUL;
                    else if (op_div0)
                        state_next = DONE;
                    else
                        state_next = DIV;
                end
            end
            MUL:  state_next = DONE;
            DIV:  if (cnt_reg == DIV_LAST) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg    <= '0;
            signed_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            result_reg <= '0;
        end else if (!flush) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        signed_reg <= op_is_signed;
                        a_reg      <= src_a;
                        b_reg      <= src_b;
                        rem_reg    <= '0;
                        quo_reg    <= mag32(src_a, op_is_signed);
                        dvs_reg    <= mag32(src_b, op_is_signed);
                        neg_q_reg  <= op_is_signed && (src_a[31] ^ src_b[31]);
                        neg_r_reg  <= op_is_signed && src_a[31];
                        cnt_reg    <= '0;
                        div0_reg   <= op_div0;
                        if (op_div0)
                            result_reg <= {src_a, 32'hFFFF_FFFF};
                    end
                end
                MUL: result_reg <= product;
                DIV: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg + 5'd1;
                end
                SIGN: begin
                    // Quotient takes the XOR of operand signs, remainder the
                    // sign of the dividend; both flags are 0 for DIVU.
                    result_reg <= {neg_r_reg ? (~rem_reg + 32'd1) : rem_reg,
                                   neg_q_reg ? (~quo_reg + 32'd1) : quo_reg};
                end
                default: ;
            endcase
        end
    end

    assign stall_req    = accept || (state_reg == MUL) || (state_reg == DIV) ||
                          (state_reg == SIGN);
    assign result_valid = (state_reg == DONE);
    assign div0         = (state_reg == DONE) && div0_reg;
    assign result       = result_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
// Directed, self-checking bench for mdu_ctrl. Cycle 0 is the cycle in which
// start is first presented; outputs are sampled 1 ns after each rising edge.
module tb_mdu_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic [63:0] result;
    logic        result_valid;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_DIV   = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_MULTU = 2'b11;

    mdu_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .stall_req    (stall_req),
        .result       (result),
        .result_valid (result_valid),
        .div0         (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
    endtask

    // Holds start until result_valid appears (bounded). Returns the cycle
    // it appeared in (-1 on timeout), whether stall_req stayed high in every
    // earlier cycle, and stall_req in the valid cycle. Drops start in DONE.
    task automatic run_to_valid(input int max_cyc, output int lat,
                                output bit stall_all_hi, output logic stall_at_valid);
        lat            = -1;
        stall_all_hi   = 1'b1;
        stall_at_valid = 1'bx;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            if (result_valid === 1'b1) begin
                lat            = k;
                stall_at_valid = stall_req;
                start          = 1'b0;
                break;
            end
            if (stall_req !== 1'b1)
                stall_all_hi = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        tick();
        tick();
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b expected 0", stall_req);
        end
        checks++;
        if (result !== 64'd0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", result_valid);
        end
        checks++;
        if (div0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_div0: got %b expected 0", div0);
        end
        $display("reset: stall=%b result=%h valid=%b div0=%b", stall_req, result, result_valid, div0);
        resetn = 1'b1;
    endtask

    task automatic test_divu();
        int   lat;
        bit   hi;
        logic sv;
        issue(OP_DIVU, 32'd100, 32'd7);
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL divu_stall_c0: got %b expected 1", stall_req);
        end
        run_to_valid(40, lat, hi, sv);
        $display("DIVU 100/7: lat=%0d result=%h div0=%b", lat, result, div0);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL divu_latency: got %0d expected 34", lat);
        end
        checks++;
        if (hi !== 1'b1) begin
            failures++;
            $display("FAIL divu_stall_c1_33: got %b expected 1", hi);
        end
        checks++;
        if (sv !== 1'b0) begin
            failures++;
            $display("FAIL divu_stall_done: got %b expected 0", sv);
        end
        checks++;
        if (result !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_result: got %h expected %h", result, {32'd2, 32'd14});
        end
        checks++;
        if (div0 !== 1'b0) begin
            failures++;
            $display("FAIL divu_div0: got %b expected 0", div0);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL divu_valid_pulse: got %b expected 0", result_valid);
        end
        checks++;
        if (result !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_result_hold: got %h expected %h", result, {32'd2, 32'd14});
        end
    endtask

    task automatic test_div_signed();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        int   lat;
        bit   hi;
        logic sv;
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          ve[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF;  ve[1] = {32'h0000_0000, 32'h8000_0000};
        va[2] = 32'd7;         vb[2] = 32'hFFFF_FFFE;  ve[2] = {32'h0000_0001, 32'hFFFF_FFFD};
        for (int i = 0; i < 3; i++) begin
            tick();
            issue(OP_DIV, va[i], vb[i]);
            run_to_valid(40, lat, hi, sv);
            $display("DIV %h/%h: lat=%0d result=%h div0=%b", va[i], vb[i], lat, result, div0);
            checks++;
            if (lat !== 34 || result !== ve[i] || div0 !== 1'b0) begin
                failures++;
                $display("FAIL div_signed_%0d: got lat=%0d result=%h div0=%b expected lat=34 result=%h div0=0",
                         i, lat, result, div0, ve[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [1:0]  vo [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        int   lat;
        bit   hi;
        logic sv;
        vo[0] = OP_MULT;  va[0] = 32'hFFFF_FFFF; vb[0] = 32'd2;          ve[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        vo[1] = OP_MULTU; va[1] = 32'hFFFF_FFFF; vb[1] = 32'd2;          ve[1] = 64'h0000_0001_FFFF_FFFE;
        vo[2] = OP_MULT;  va[2] = 32'h7FFF_FFFF; vb[2] = 32'h8000_0000;  ve[2] = 64'hC000_0000_8000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            issue(vo[i], va[i], vb[i]);
            run_to_valid(10, lat, hi, sv);
            $display("MUL op=%b %h*%h: lat=%0d result=%h", vo[i], va[i], vb[i], lat, result);
            checks++;
            if (lat !== 2 || result !== ve[i] || hi !== 1'b1 || sv !== 1'b0) begin
                failures++;
                $display("FAIL mul_%0d: got lat=%0d result=%h stall_ok=%b stall_done=%b expected lat=2 result=%h stall_ok=1 stall_done=0",
                         i, lat, result, hi, sv, ve[i]);
            end
        end
    endtask

    task automatic test_div0();
        int   lat;
        bit   hi;
        logic sv;
        tick();
        issue(OP_DIVU, 32'd5, 32'd0);
        run_to_valid(10, lat, hi, sv);
        $display("DIVU 5/0: lat=%0d result=%h div0=%b stall=%b", lat, result, div0, sv);
        checks++;
        if (lat !== 1 || div0 !== 1'b1 || sv !== 1'b0) begin
            failures++;
            $display("FAIL div0_divu_flags: got lat=%0d div0=%b stall=%b expected lat=1 div0=1 stall=0",
                     lat, div0, sv);
        end
        checks++;
        if (result !== {32'd5, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL div0_divu_result: got %h expected %h", result, {32'd5, 32'hFFFF_FFFF});
        end
        tick();
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        run_to_valid(10, lat, hi, sv);
        $display("DIV fffffff0/0: lat=%0d result=%h div0=%b", lat, result, div0);
        checks++;
        if (lat !== 1 || div0 !== 1'b1 || result !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL div0_div: got lat=%0d div0=%b result=%h expected lat=1 div0=1 result=%h",
                     lat, div0, result, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_flush();
        int bad_valid;
        tick();
        issue(OP_DIV, 32'd1000, 32'd3);
        bad_valid = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (result_valid !== 1'b0) bad_valid++;
        end
        // cycle 10: flush, EX drops its request
        flush = 1'b1;
        start = 1'b0;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall_c11: got %b expected 0", stall_req);
        end
        if (result_valid !== 1'b0) bad_valid++;
        for (int k = 12; k <= 40; k++) begin
            tick();
            if (result_valid !== 1'b0) bad_valid++;
        end
        $display("flush DIV at cycle 10: stray valid cycles=%0d", bad_valid);
        checks++;
        if (bad_valid !== 0) begin
            failures++;
            $display("FAIL flush_no_valid: got %0d valid cycles expected 0", bad_valid);
        end
        // flush and start together in IDLE: flush wins
        issue(OP_MULT, 32'd3, 32'd5);
        flush = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_stall: got %b expected 0", stall_req);
        end
        tick();
        flush = 1'b0;
        start = 1'b0;
        bad_valid = 0;
        for (int k = 0; k < 5; k++) begin
            if (result_valid !== 1'b0 || stall_req !== 1'b0) bad_valid++;
            tick();
        end
        $display("flush+start in IDLE: activity cycles=%0d", bad_valid);
        checks++;
        if (bad_valid !== 0) begin
            failures++;
            $display("FAIL flush_start_ignored: got %0d active cycles expected 0", bad_valid);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        bit   hi;
        logic sv;
        tick();
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd13);
        for (int k = 1; k <= 20; k++) tick();
        // cycle 20: reset mid-divide
        resetn = 1'b0;
        start  = 1'b0;
        tick();
        $display("reset mid-DIVU: stall=%b result=%h valid=%b div0=%b", stall_req, result, result_valid, div0);
        checks++;
        if (stall_req !== 1'b0 || result !== 64'd0 || result_valid !== 1'b0 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got stall=%b result=%h valid=%b div0=%b expected all 0",
                     stall_req, result, result_valid, div0);
        end
        resetn = 1'b1;
        issue(OP_MULT, 32'd3, 32'd4);
        run_to_valid(10, lat, hi, sv);
        $display("MULT 3*4 after reset: lat=%0d result=%h", lat, result);
        checks++;
        if (lat !== 2 || result !== 64'd12) begin
            failures++;
            $display("FAIL reset_then_mult: got lat=%0d result=%h expected lat=2 result=%h",
                     lat, result, 64'd12);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   hi;
        logic sv;
        tick();
        issue(OP_MULTU, 32'd6, 32'd7);
        tick();
        tick();
        // cycle 2: DONE; present a new request, which DONE must ignore
        checks++;
        if (result_valid !== 1'b1 || result !== 64'd42) begin
            failures++;
            $display("FAIL b2b_first: got valid=%b result=%h expected valid=1 result=%h",
                     result_valid, result, 64'd42);
        end
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        tick();
        // cycle 3: IDLE accepting the second request
        checks++;
        if (stall_req !== 1'b1 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got stall=%b valid=%b expected stall=1 valid=0",
                     stall_req, result_valid);
        end
        run_to_valid(10, lat, hi, sv);
        $display("MULTU back-to-back: lat=%0d result=%h", lat, result);
        checks++;
        if (lat !== 2 || result !== 64'h0000_0001_0000_0000) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d result=%h expected lat=2 result=%h",
                     lat, result, 64'h0000_0001_0000_0000);
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_mul();
        test_div0();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
